keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan_if.sv | 17 +
 rtl/keypad_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_if
//  Purpose  : Key-code valid/ready channel from the scanner to its consumer.
//  Revision : 1.0
// ============================================================================
interface keypad_scan_if #(
  parameter int K = 4
) ();
  logic [K-1:0] key;
  logic         key_valid;
  logic         key_ready;

  modport master (output key, output key_valid, input key_ready);
  modport slave  (input key, input key_valid, output key_ready);
endinterface
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : Column-scanning keypad controller with debounce and a
//             one-deep valid/ready key-code output.
//  Revision : 1.0
// ============================================================================
module keypad_scan #(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int DWELL    = 16,
  parameter int DEBOUNCE = 4,
  parameter int M        = $clog2(COLS),
  parameter int K        = $clog2(ROWS*COLS)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [ROWS-1:0] row,
  output logic      [M-1:0]    sel,
  output logic                 overrun,
  input  wire logic            clr_ovr,
  keypad_scan_if.master        bus
);

  localparam int DW = $clog2(DWELL);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   row_s1_q, row_s_q;
  logic [M-1:0]      sel_q, sel_d, sel_next;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [CW-1:0]     match_q, match_d;
  logic [CW-1:0]     rel_q, rel_d;
  logic [M-1:0]      cap_col_q, cap_col_d;
  logic [RW-1:0]     cap_row_q, cap_row_d;
  logic [K-1:0]      key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              overrun_q, overrun_d;
  logic              dwell_end, row_hit, load, drop;
  logic [RW-1:0]     row_idx;
  logic [K-1:0]      key_code;

  assign dwell_end = (dwell_q == DW'(DWELL - 1));
  assign row_hit   = |row_s_q;
  assign sel_next  = (sel_q == M'(COLS - 1)) ? '0 : sel_q + M'(1);
  assign key_code  = K'(cap_row_q) * K'(COLS) + K'(cap_col_q);
  assign load      = (state_q == ST_EMIT) && (!key_valid_q || bus.key_ready);
  assign drop      = (state_q == ST_EMIT) && !load;

  // Descending scan so the last assignment leaves the lowest set row.
  always_comb begin
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_s_q[r]) row_idx = RW'(r);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    match_d   = match_q;
    rel_d     = rel_q;
    cap_col_d = cap_col_q;
    cap_row_d = cap_row_q;
    // SEL only moves on a dwell end, so wrapping here also restarts the dwell.
    dwell_d   = dwell_end ? '0 : dwell_q + DW'(1);

    case (state_q)
      ST_SCAN: begin
        if (dwell_end) begin
          if (!row_hit) begin
            sel_d = sel_next;
          end else begin
            cap_col_d = sel_q;
            cap_row_d = row_idx;
            match_d   = CW'(1);
            state_d   = (DEBOUNCE == 1) ? ST_EMIT : ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (dwell_end) begin
          if (row_hit && (row_idx == cap_row_q)) begin
            match_d = match_q + CW'(1);
            if (match_q + CW'(1) == CW'(DEBOUNCE)) state_d = ST_EMIT;
          end else begin
            state_d = ST_SCAN;
            sel_d   = sel_next;
          end
        end
      end
      ST_EMIT: begin
        rel_d   = '0;
        state_d = ST_RELEASE;
      end
      default: begin
        if (dwell_end) begin
          if (row_hit) begin
            rel_d = '0;
          end else if (rel_q + CW'(1) == CW'(DEBOUNCE)) begin
            rel_d   = '0;
            state_d = ST_SCAN;
            sel_d   = sel_next;
          end else begin
            rel_d = rel_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    if (load) begin
      key_d       = key_code;
      key_valid_d = 1'b1;
    end else if (key_valid_q && bus.key_ready) begin
      key_valid_d = 1'b0;
    end
    // Set beats a coincident clear.
    overrun_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_s1_q    <= '0;
      row_s_q     <= '0;
      sel_q       <= '0;
      dwell_q     <= '0;
      match_q     <= '0;
      rel_q       <= '0;
      cap_col_q   <= '0;
      cap_row_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_s1_q    <= row;
      row_s_q     <= row_s1_q;
      sel_q       <= sel_d;
      dwell_q     <= dwell_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      cap_col_q   <= cap_col_d;
      cap_row_q   <= cap_row_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sel           = sel_q;
  assign overrun       = overrun_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;

endmodule
`default_nettype wire
